if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg -- shared widths, encodings and IF state constants for the
// byte-serial instruction fetch stage.
package if_stage_pkg;

  // Field widths (stallRange / addrRange / instRange / byte)
  localparam int STALL_W = 6;
  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int BYTE_W  = 8;

  // Bit of the stall vector that means IF/ID is not accepting
  localparam int STALL_IF = 1;

  localparam logic [31:0] ZERO32   = 32'h0000_0000;
  localparam logic        JUMP     = 1'b1;
  localparam logic        NO_STALL = 1'b0;

  // Bytes per instruction; also the "all issued" value of the issue counter
  localparam logic [2:0] BYTES_PER_INST = 3'd4;

  // IF state encodings
  localparam logic [1:0] IF_FETCH = 2'd0;
  localparam logic [1:0] IF_HOLD  = 2'd1;
  localparam logic [1:0] IF_FLUSH = 2'd2;

endpackage

// File: rtl/if_stage.sv
// if_stage -- instruction fetch over a byte-wide memory port.
// Issues four byte requests starting at pc_in, collects the returned bytes
// (data arrives one cycle after its grant), and delivers a little-endian
// 32-bit instruction with a one-cycle valid pulse.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (0 freezes everything)
//   pc_in / pcJump_in / stall_in    : from PC stage and stall controller
//   memReq_out / memAddr_out        : byte request to memory controller
//   memGrant_in / memData_in        : grant this cycle, data next cycle
//   IF_pc_out / IF_inst_out / IF_valid_out : delivered instruction
//   IF_stallReq_out                 : combinational hold request for PC
module if_stage
  import if_stage_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pcJump_in,
  input  logic [STALL_W-1:0] stall_in,
  output logic              memReq_out,
  output logic [ADDR_W-1:0] memAddr_out,
  input  logic              memGrant_in,
  input  logic [BYTE_W-1:0] memData_in,
  output logic [ADDR_W-1:0] IF_pc_out,
  output logic [INST_W-1:0] IF_inst_out,
  output logic              IF_valid_out,
  output logic              IF_stallReq_out
);

  logic [1:0]              r_state;
  logic [2:0]              r_issued;        // bytes granted so far (0..4)
  logic                    r_inflight;      // a granted byte is on memData_in now
  logic [1:0]              r_inflight_idx;  // which byte that is
  logic [2:0][BYTE_W-1:0]  r_bytes;         // bytes 0..2; byte 3 goes straight out
  logic [ADDR_W-1:0]       r_pc;
  logic [INST_W-1:0]       r_inst;
  logic                    r_valid;

  logic w_fetch, w_req, w_grant, w_last, w_jump, w_hold_req;
  logic w_unused_stall;

  assign w_fetch    = (r_state == IF_FETCH);
  assign w_jump     = (pcJump_in == JUMP);
  assign w_hold_req = (stall_in[STALL_IF] != NO_STALL);
  // A jump kills the request in the same cycle; a frozen pipe never requests.
  assign w_req      = rdy_in && w_fetch && (r_issued < BYTES_PER_INST) && !w_jump;
  assign w_grant    = w_req && memGrant_in;
  // Final byte of the instruction is on the data bus this cycle.
  assign w_last     = w_fetch && r_inflight && (r_inflight_idx == 2'd3);

  assign w_unused_stall = ^{stall_in[STALL_W-1:STALL_IF+1], stall_in[STALL_IF-1:0]};

  assign memReq_out      = w_req;
  assign memAddr_out     = pc_in + ADDR_W'(r_issued);
  assign IF_stallReq_out = !w_last;
  assign IF_pc_out       = r_pc;
  assign IF_inst_out     = r_inst;
  assign IF_valid_out    = r_valid;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state        <= IF_FETCH;
      r_issued       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
      r_bytes        <= '0;
      r_pc           <= ZERO32;
      r_inst         <= ZERO32;
      r_valid        <= 1'b0;
    end else if (rdy_in) begin
      if (w_jump) begin
        // Drop everything collected or still in flight; one dead cycle follows.
        r_state        <= IF_FLUSH;
        r_issued       <= '0;
        r_inflight     <= 1'b0;
        r_inflight_idx <= '0;
        r_bytes        <= '0;
        r_valid        <= 1'b0;
      end else begin
        case (r_state)
          IF_FETCH: begin
            r_valid        <= 1'b0;
            r_inflight     <= w_grant;
            r_inflight_idx <= r_issued[1:0];
            if (w_grant) r_issued <= r_issued + 3'd1;
            if (w_last) begin
              // No grant can coincide here: all four bytes are already issued.
              r_inst   <= {memData_in, r_bytes};
              r_pc     <= pc_in;
              r_valid  <= 1'b1;
              r_issued <= '0;
              r_bytes  <= '0;
              if (w_hold_req) r_state <= IF_HOLD;
            end else if (r_inflight) begin
              r_bytes[r_inflight_idx] <= memData_in;
            end
          end
          IF_HOLD: begin
            // Outputs stay valid through the cycle ID finally accepts them.
            if (!w_hold_req) begin
              r_state <= IF_FETCH;
              r_valid <= 1'b0;
            end
          end
          IF_FLUSH: r_state <= IF_FETCH;
          default:  r_state <= IF_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, pcJump_in, memGrant_in;
  logic [31:0] pc_in;
  logic [5:0]  stall_in;
  logic [7:0]  memData_in;
  logic        memReq_out, IF_valid_out, IF_stallReq_out;
  logic [31:0] memAddr_out, IF_pc_out, IF_inst_out;

  always #5 clk_in = ~clk_in;

  if_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc_in(pc_in),
    .pcJump_in(pcJump_in), .stall_in(stall_in), .memReq_out(memReq_out),
    .memAddr_out(memAddr_out), .memGrant_in(memGrant_in), .memData_in(memData_in),
    .IF_pc_out(IF_pc_out), .IF_inst_out(IF_inst_out), .IF_valid_out(IF_valid_out),
    .IF_stallReq_out(IF_stallReq_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum int {M_FETCH, M_HOLD, M_FLUSH} mmode_t;
  mmode_t      m_mode;
  bit          m_init = 1'b0;
  int          m_issued;
  logic [7:0]  m_q[$];     // bytes received so far, in order
  int          m_fly[$];   // indices of granted bytes whose data is due next
  logic [31:0] m_pc, m_inst;
  logic        m_valid;

  function automatic logic m_req();
    return rdy_in && (m_mode == M_FETCH) && (m_issued < 4) && !pcJump_in;
  endfunction

  function automatic logic m_stallreq();
    return !((m_mode == M_FETCH) && (m_fly.size() > 0) && (m_q.size() == 3));
  endfunction

  task automatic model_reset();
    m_init = 1'b1; m_mode = M_FETCH; m_issued = 0;
    m_q.delete(); m_fly.delete();
    m_pc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic req;
    req = m_req();
    if (!rst_in) model_reset();
    else if (rdy_in) begin
      if (pcJump_in) begin
        m_q.delete(); m_fly.delete(); m_issued = 0; m_valid = 1'b0; m_mode = M_FLUSH;
      end else if (m_mode == M_FLUSH) m_mode = M_FETCH;
      else if (m_mode == M_HOLD) begin
        if (!stall_in[1]) begin m_mode = M_FETCH; m_valid = 1'b0; end
      end else begin
        m_valid = 1'b0;
        if (m_fly.size() > 0) begin
          void'(m_fly.pop_front());
          m_q.push_back(memData_in);
          if (m_q.size() == 4) begin
            m_inst = {m_q[3], m_q[2], m_q[1], m_q[0]};
            m_pc = pc_in; m_valid = 1'b1; m_q.delete(); m_issued = 0;
            if (stall_in[1]) m_mode = M_HOLD;
          end
        end
        if (req && memGrant_in) begin m_fly.push_back(m_issued); m_issued++; end
      end
    end
  endtask

  // ---------------- drivers ----------------
  logic        s_req, s_stall, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic drive(input logic rst, input logic rdy, input logic [31:0] pc, input logic jump,
                       input logic [5:0] stall, input logic grant, input logic [7:0] data);
    rst_in = rst; rdy_in = rdy; pc_in = pc; pcJump_in = jump;
    stall_in = stall; memGrant_in = grant; memData_in = data;
    #2;
    s_req = memReq_out; s_addr = memAddr_out; s_stall = IF_stallReq_out;
    s_valid = IF_valid_out; s_inst = IF_inst_out; s_pc = IF_pc_out;
    if (m_init && rst) begin
      chk("memReq", 32'(memReq_out), 32'(m_req()));
      if (m_req()) chk("memAddr", memAddr_out, pc + 32'(m_issued));
      chk("stallReq", 32'(IF_stallReq_out), 32'(m_stallreq()));
    end
    if (m_init) begin
      chk("IF_valid", 32'(IF_valid_out), 32'(m_valid));
      chk("IF_pc", IF_pc_out, m_pc);
      chk("IF_inst", IF_inst_out, m_inst);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic [31:0] pc, input logic jump,
                     input logic [5:0] stall, input logic grant, input logic [7:0] data);
    drive(rst, rdy, pc, jump, stall, grant, data);
    tick();
  endtask

  task automatic do_reset(input logic [31:0] pc);
    cyc(1'b0, 1'b1, pc, 1'b0, 6'd0, 1'b0, 8'h00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        grant;
    logic [7:0]  data;
    logic [31:0] pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tv[7];

  logic        r_rst, r_rdy, r_jump, r_grant;
  logic [5:0]  r_stall;
  logic [7:0]  r_data;
  logic [31:0] r_pc;
  int          vcount, rcount;

  initial begin
    tv[0] = '{1'b1, 8'hEE, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    tv[1] = '{1'b1, 8'h13, 32'h0, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0};
    tv[2] = '{1'b1, 8'h05, 32'h0, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0};
    tv[3] = '{1'b1, 8'h10, 32'h0, 1'b1, 32'h3, 1'b1, 1'b0, 32'h0};
    tv[4] = '{1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    tv[5] = '{1'b0, 8'hEE, 32'h4, 1'b1, 32'h4, 1'b1, 1'b1, 32'h0010_0513};
    tv[6] = '{1'b0, 8'hEE, 32'h4, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0010_0513};

    // Reset state, then basic fetch from the table
    do_reset(32'h0);
    chk("rst_valid", 32'(IF_valid_out), 32'h0);
    chk("rst_inst", IF_inst_out, 32'h0);
    chk("rst_pc", IF_pc_out, 32'h0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, tv[i].pc, 1'b0, 6'd0, tv[i].grant, tv[i].data);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tv[i].e_req));
      if (tv[i].e_req) chk($sformatf("tbl%0d_addr", i), s_addr, tv[i].e_addr);
      chk($sformatf("tbl%0d_stall", i), 32'(s_stall), 32'(tv[i].e_stall));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tv[i].e_valid));
      chk($sformatf("tbl%0d_inst", i), s_inst, tv[i].e_inst);
      chk($sformatf("tbl%0d_pc", i), s_pc, 32'h0);
      tick();
    end

    // Grants withheld for two cycles: address re-presented, valid two cycles late
    do_reset(32'h0);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'hEE);
    cyc(1, 1, 32'h0, 0, 6'd0, 0, 8'h13); chk("nogr_addr1", s_addr, 32'h1);
    cyc(1, 1, 32'h0, 0, 6'd0, 0, 8'hEE); chk("nogr_addr2", s_addr, 32'h1);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'hEE); chk("nogr_addr3", s_addr, 32'h1);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h05);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h10); chk("nogr_vlate", 32'(s_valid), 32'h0);
    cyc(1, 1, 32'h0, 0, 6'd0, 0, 8'h00);
    cyc(1, 1, 32'h4, 0, 6'd0, 0, 8'hEE);
    chk("nogr_valid", 32'(s_valid), 32'h1);
    chk("nogr_inst", s_inst, 32'h0010_0513);

    // Jump after two bytes: dead cycle, no delivery, refetch from 0x100
    do_reset(32'h200);
    cyc(1, 1, 32'h200, 0, 6'd0, 1, 8'hEE);
    cyc(1, 1, 32'h200, 0, 6'd0, 1, 8'hAA);
    cyc(1, 1, 32'h200, 1, 6'd0, 1, 8'hBB); chk("jmp_req_same", 32'(s_req), 32'h0);
    cyc(1, 1, 32'h100, 0, 6'd0, 1, 8'hEE); chk("jmp_dead", 32'(s_req), 32'h0);
    cyc(1, 1, 32'h100, 0, 6'd0, 1, 8'hEE); chk("jmp_a0", s_addr, 32'h100);
    cyc(1, 1, 32'h100, 0, 6'd0, 1, 8'h11);
    cyc(1, 1, 32'h100, 0, 6'd0, 1, 8'h22);
    cyc(1, 1, 32'h100, 0, 6'd0, 1, 8'h33); chk("jmp_a3", s_addr, 32'h103);
    cyc(1, 1, 32'h100, 0, 6'd0, 0, 8'h44); chk("jmp_novalid", 32'(s_valid), 32'h0);
    cyc(1, 1, 32'h104, 0, 6'd0, 0, 8'hEE);
    chk("jmp_inst", s_inst, 32'h4433_2211);
    chk("jmp_pc", s_pc, 32'h100);

    // Stall held three cycles at completion
    do_reset(32'h0);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'hEE);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h13);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h05);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h10);
    cyc(1, 1, 32'h0, 0, 6'b000010, 0, 8'h00);
    vcount = 0; rcount = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 32'h4, 0, (i < 2) ? 6'b000010 : 6'd0, 1, 8'hEE);
      vcount += int'(s_valid); rcount += int'(s_req);
      chk($sformatf("hold%0d_inst", i), s_inst, 32'h0010_0513);
    end
    cyc(1, 1, 32'h4, 0, 6'd0, 1, 8'hEE);
    vcount += int'(s_valid);
    chk("hold_vcnt", 32'(vcount), 32'd3);
    chk("hold_noreq", 32'(rcount), 32'd0);
    chk("hold_resume", 32'(s_req), 32'h1);

    // Freeze two cycles mid-fetch; the pending byte is re-presented on resume
    do_reset(32'h0);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'hEE);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h13);
    cyc(1, 0, 32'h0, 0, 6'd0, 1, 8'hEE); chk("frz_req0", 32'(s_req), 32'h0);
    cyc(1, 0, 32'h0, 0, 6'd0, 1, 8'hEE); chk("frz_req1", 32'(s_req), 32'h0);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h05); chk("frz_addr", s_addr, 32'h2);
    cyc(1, 1, 32'h0, 0, 6'd0, 1, 8'h10);
    cyc(1, 1, 32'h0, 0, 6'd0, 0, 8'h00);
    cyc(1, 1, 32'h4, 0, 6'd0, 0, 8'hEE);
    chk("frz_inst", s_inst, 32'h0010_0513);

    // Reset mid-fetch (beats rdy=0 and jump), then wrapped refetch
    do_reset(32'h10);
    cyc(1, 1, 32'h10, 0, 6'd0, 1, 8'hEE);
    cyc(1, 1, 32'h10, 0, 6'd0, 1, 8'h01);
    cyc(1, 1, 32'h10, 0, 6'd0, 1, 8'h02);
    cyc(1, 1, 32'h10, 0, 6'd0, 1, 8'h03);
    cyc(1, 1, 32'h10, 0, 6'd0, 0, 8'h04);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'hEE); chk("wr_inst0", s_inst, 32'h0403_0201);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'hAA);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'hBB);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'hCC);
    cyc(0, 0, 32'hFFFF_FFFE, 1, 6'd0, 0, 8'hDD);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'hEE);
    chk("wr_rst_inst", s_inst, 32'h0);
    chk("wr_rst_pc", s_pc, 32'h0);
    chk("wr_rst_valid", 32'(s_valid), 32'h0);
    chk("wr_a0", s_addr, 32'hFFFF_FFFE);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'h55); chk("wr_a1", s_addr, 32'hFFFF_FFFF);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'h66); chk("wr_a2", s_addr, 32'h0);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 1, 8'h77); chk("wr_a3", s_addr, 32'h1);
    cyc(1, 1, 32'hFFFF_FFFE, 0, 6'd0, 0, 8'h88);
    cyc(1, 1, 32'h2, 0, 6'd0, 0, 8'hEE);
    chk("wr_inst", s_inst, 32'h8877_6655);
    chk("wr_pc", s_pc, 32'hFFFF_FFFE);

    // Randomized traffic against the model
    r_pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      r_rst   = ($urandom_range(0, 199) != 0);
      r_rdy   = ($urandom_range(0, 9) != 0);
      r_jump  = ($urandom_range(0, 24) == 0);
      r_stall = 6'($urandom);
      r_grant = ($urandom_range(0, 9) < 6);
      r_data  = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        r_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      cyc(r_rst, r_rdy, r_pc, r_jump, r_stall, r_grant, r_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
